rv_multicycle_ctrl: RTL



---
 rtl/rv_multicycle_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle RV32I control FSM with memory timeouts; RV_CTRL_PERF_EN adds cycle/instruction counters
module rv_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
`ifdef RV_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] INST,
  input  logic        IMEM_RDY,
  input  logic        DMEM_RDY,
  input  logic        ZERO,
  output logic        IMEM_RE,
  output logic        IR_WE,
  output logic        PC_WE,
  output logic        PC_SEL,
  output logic        RF_WE,
  output logic        ALU_SRC_B,
  output logic [3:0]  ALU_OP,
  output logic        DMEM_RE,
  output logic        DMEM_WE,
  output logic        WB_SEL,
  output logic        BUSY,
  output logic        HALTED,
  output logic        ERR,
  output logic [2:0]  STATE
`ifdef RV_CTRL_PERF_EN
  , output logic [CNT_W-1:0] CYC_CNT
  , output logic [CNT_W-1:0] INSTR_CNT
`endif
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

  logic [2:0]    r_state, w_next;
  logic [31:0]   r_ir;
  logic [TW-1:0] r_cnt;
  logic          r_err, w_err_set;
  logic [6:0]    w_op;
  logic [2:0]    w_f3;
  logic          w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br, w_br_ok, w_ecall;
  logic          w_fetch, w_exec, w_mem, w_wb, w_timeout, w_taken;

  assign w_op      = r_ir[6:0];
  assign w_f3      = r_ir[14:12];
  assign w_is_r    = w_op == 7'b0110011;
  assign w_is_i    = w_op == 7'b0010011;
  assign w_is_lw   = w_op == 7'b0000011;
  assign w_is_sw   = w_op == 7'b0100011;
  assign w_is_br   = w_op == 7'b1100011;
  assign w_br_ok   = w_f3[2:1] == 2'b00;
  assign w_ecall   = r_ir == 32'h0000_0073;
  assign w_fetch   = r_state == S_FETCH;
  assign w_exec    = r_state == S_EXEC;
  assign w_mem     = r_state == S_MEM;
  assign w_wb      = r_state == S_WB;
  assign w_timeout = r_cnt == TMAX;
  assign w_taken   = w_is_br & (w_f3[0] ? !ZERO : ZERO);

  // next-state selection and error-halt detection
  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE:   w_next = START ? S_FETCH : S_IDLE;
      S_FETCH: begin
        w_next    = w_timeout ? S_HALT : IMEM_RDY ? S_DECODE : S_FETCH;
        w_err_set = w_timeout;
      end
      S_DECODE: begin
        w_next    = (w_ecall || w_is_r || w_is_i || w_is_lw || w_is_sw || (w_is_br && w_br_ok)) ? (w_ecall ? S_HALT : S_EXEC) : S_HALT;
        w_err_set = !(w_ecall || w_is_r || w_is_i || w_is_lw || w_is_sw || (w_is_br && w_br_ok));
      end
      S_EXEC:   w_next = w_is_br ? S_FETCH : (w_is_lw || w_is_sw) ? S_MEM : S_WB;
      S_MEM: begin
        w_next    = w_timeout ? S_HALT : DMEM_RDY ? (w_is_lw ? S_WB : S_FETCH) : S_MEM;
        w_err_set = w_timeout;
      end
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // datapath strobes decoded from state, latched instruction and handshake inputs
  always_comb begin
    IMEM_RE   = w_fetch & !w_timeout;
    IR_WE     = w_fetch & !w_timeout & IMEM_RDY;
    PC_WE     = (w_fetch & !w_timeout & IMEM_RDY) | (w_exec & w_taken);
    PC_SEL    = w_exec & w_taken;
    RF_WE     = w_wb;
    ALU_SRC_B = w_exec & (w_is_i | w_is_lw | w_is_sw);
    ALU_OP    = !w_exec ? 4'b0000 : w_is_r ? {r_ir[30], w_f3} : w_is_i ? {r_ir[30] & (w_f3 == 3'b101), w_f3} : w_is_br ? 4'b1000 : 4'b0000;
    DMEM_RE   = w_mem & !w_timeout & w_is_lw;
    DMEM_WE   = w_mem & !w_timeout & w_is_sw;
    WB_SEL    = w_wb & w_is_lw;
    BUSY      = r_state != S_IDLE && r_state != S_HALT;
    HALTED    = r_state == S_HALT;
    ERR       = r_err;
    STATE     = r_state;
  end

  // state, sticky error, instruction latch and wait-cycle counter (cleared on any state change)
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= r_err | w_err_set;
      if (IR_WE) r_ir <= INST;
      r_cnt   <= (w_next != r_state) ? '0 : ((w_fetch && !IMEM_RDY) || (w_mem && !DMEM_RDY)) ? r_cnt + TW'(1) : r_cnt;
    end
  end

`ifdef RV_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cyc, r_ins;
  // saturating busy-cycle and retired-instruction counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cyc <= '0;
      r_ins <= '0;
    end else begin
      if (BUSY && !(&r_cyc)) r_cyc <= r_cyc + CNT_W'(1);
      if (w_next == S_FETCH && (w_exec || w_mem || w_wb) && !(&r_ins)) r_ins <= r_ins + CNT_W'(1);
    end
  end
  assign CYC_CNT   = r_cyc;
  assign INSTR_CNT = r_ins;
`endif
endmodule
